// File: rtl/or_and_reduce_pkg.sv
// Shared types and sizing helpers for the OR-then-AND reduction scheduler.
package or_and_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } sched_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 16;

    // Bits needed to hold a count in the range 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/or_and_reduce_unit.sv
// Combinational coverage check: all_ok = &(a | b), zcnt = positions where both operands are 0.
module or_and_reduce_unit
    import or_and_reduce_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             all_ok,
    output logic [CNT_W-1:0] zcnt
);

    logic [WIDTH-1:0] cover_bits;

    assign cover_bits = a | b;
    assign all_ok     = &cover_bits;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        zcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            zcnt = zcnt + CNT_W'(~cover_bits[i]);
        end
    end

endmodule

// File: rtl/or_and_reduce_sched.sv
// Round-robin scheduler serialising N_REQ operand pairs through one shared reduction unit.
module or_and_reduce_sched
    import or_and_reduce_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_all,
    output logic [CNT_W-1:0]       rsp_zcnt,
    output logic                   busy
);

    sched_state_t     state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_all_q;
    logic [CNT_W-1:0] rsp_zcnt_q;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  rr_ptr_d;
    logic             unit_all;
    logic [CNT_W-1:0] unit_zcnt;

    // First set lane at or after ptr, wrapping; scanning backwards lets the nearest one win.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (valid[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    assign winner   = rr_pick(req_valid, rr_ptr_q);
    assign rr_ptr_d = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && |req_valid) req_ready[winner] = 1'b1;
    end

    or_and_reduce_unit #(.WIDTH(WIDTH)) u_unit (
        .a      (a_q),
        .b      (b_q),
        .all_ok (unit_all),
        .zcnt   (unit_zcnt)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_all_q   <= 1'b0;
            rsp_zcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        a_q     <= req_a[int'(winner)*WIDTH +: WIDTH];
                        b_q     <= req_b[int'(winner)*WIDTH +: WIDTH];
                        id_q    <= winner;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_all_q   <= unit_all;
                    rsp_zcnt_q  <= unit_zcnt;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_all   = rsp_all_q;
    assign rsp_zcnt  = rsp_zcnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_or_and_reduce_sched.sv
// Scoreboard bench: grants are predicted by a round-robin model, results by a popcount model.
module tb_or_and_reduce_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;
    localparam int CW = 5;

    typedef struct {
        int id;
        int all;
        int zcnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic            rsp_all;
    logic [CW-1:0]   rsp_zcnt;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t exp_q[$];
    int   glog[$];
    int   gcyc[$];
    int   m_ptr     = 0;
    bit   in_flight = 1'b0;
    int   g_cyc     = 0;

    or_and_reduce_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_all   (rsp_all),
        .rsp_zcnt  (rsp_zcnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard: predicts grants, tracks the single in-flight request, checks responses.
    int          m_win;
    logic [N-1:0] m_mask;
    logic [W-1:0] m_a, m_b;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_flight = 1'b0;
            m_ptr     = 0;
            check("ready_in_reset", req_ready, '0);
        end else begin
            m_win  = -1;
            m_mask = '0;
            if (!in_flight) begin
                for (int k = 0; k < N; k++) begin
                    if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                end
            end
            if (m_win >= 0) m_mask[m_win] = 1'b1;
            check("req_ready", req_ready, m_mask);
            check("busy", busy, in_flight);
            check("rsp_valid", rsp_valid, in_flight && (cyc >= g_cyc + 2));
            if (rsp_valid && exp_q.size() > 0) begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_all", rsp_all, exp_q[0].all);
                check("rsp_zcnt", rsp_zcnt, exp_q[0].zcnt);
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    m_ptr = (exp_q[0].id + 1) % N;
                    void'(exp_q.pop_front());
                end
                in_flight = 1'b0;
            end
            if (m_win >= 0) begin
                m_a    = req_a[m_win*W +: W];
                m_b    = req_b[m_win*W +: W];
                m_e.id   = m_win;
                m_e.zcnt = $countones(~(m_a | m_b));
                m_e.all  = (m_e.zcnt == 0) ? 1 : 0;
                exp_q.push_back(m_e);
                in_flight = 1'b1;
                g_cyc     = cyc;
                glog.push_back(m_win);
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic set_lane(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[lane*W +: W] = a;
        req_b[lane*W +: W] = b;
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < N; l++) begin
            case ($urandom_range(0, 3))
                0:       set_lane(l, '0, '0);
                1:       set_lane(l, '1, W'($urandom));
                default: set_lane(l, W'($urandom), W'($urandom));
            endcase
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int limit);
        int n;
        n = 0;
        while (!rsp_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", rsp_valid, 1);
    endtask

    task automatic wait_grants(input int target, input int limit);
        int n;
        n = 0;
        while (glog.size() < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", glog.size() >= target, 1);
    endtask

    task automatic directed(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int exp_all, input int exp_zcnt);
        logic [N-1:0] m;
        m = '0;
        m[lane] = 1'b1;
        @(posedge clk); #1;
        set_lane(lane, a, b);
        req_valid = m; rsp_ready = 1'b0;
        @(negedge clk);
        check("dir_ready", req_ready, m);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(20);
        check("dir_id", rsp_id, lane);
        check("dir_all", rsp_all, exp_all);
        check("dir_zcnt", rsp_zcnt, exp_zcnt);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    int          cap_id, cap_all, cap_zcnt, nxt, n0;

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_all", rsp_all, 0);
        check("rst_rsp_zcnt", rsp_zcnt, 0);
        check("rst_busy", busy, 0);

        directed(2, 16'h00FF, 16'hFF00, 1, 0);
        directed(1, 16'h0000, 16'h0001, 0, 15);
        directed(1, 16'h0000, 16'h0000, 0, 16);
        directed(3, 16'hFFFF, 16'hFFFF, 1, 0);

        // All lanes requesting with the pointer at 0: strict rotation, one result per 3 cycles.
        do_reset();
        glog.delete(); gcyc.delete();
        rand_lanes();
        req_valid = '1; rsp_ready = 1'b1;
        wait_grants(5, 40);
        @(posedge clk); #1 req_valid = '0;
        for (int i = 0; i < glog.size() && i < 5; i++) begin
            check("rr_order", glog[i], i % N);
            if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        repeat (6) @(posedge clk);

        // Downstream stall with lanes 0 and 3 pending.
        #1 rsp_ready = 1'b0; rand_lanes(); req_valid = 4'b1001;
        wait_rsp(20);
        cap_id = rsp_id; cap_all = rsp_all; cap_zcnt = rsp_zcnt;
        repeat (10) begin
            @(negedge clk);
            check("stall_ready", req_ready, '0);
            check("stall_valid", rsp_valid, 1);
            check("stall_id", rsp_id, cap_id);
            check("stall_all", rsp_all, cap_all);
            check("stall_zcnt", rsp_zcnt, cap_zcnt);
        end
        nxt = -1;
        for (int k = 1; k <= N; k++) begin
            if (nxt < 0 && (((cap_id + k) % N) == 0 || ((cap_id + k) % N) == 3)) nxt = (cap_id + k) % N;
        end
        n0 = glog.size();
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_grants(n0 + 1, 20);
        if (glog.size() > n0) check("stall_next_grant", glog[n0], nxt);
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);

        // Reset while holding a lane-3 result.
        do_reset();
        #1 req_valid = 4'b1000; rsp_ready = 1'b0;
        wait_rsp(20);
        check("hold_id3", rsp_id, 3);
        @(posedge clk); #1 req_valid = '0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", rsp_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);

        // Lane 0 requests only while lane 1 is being served, then withdraws.
        #1 rsp_ready = 1'b0; glog.delete(); gcyc.delete(); req_valid = 4'b0010;
        @(posedge clk); #1 req_valid = 4'b0001;
        repeat (3) @(posedge clk);
        #1 req_valid = '0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        check("drop_grants", glog.size(), 1);
        if (glog.size() > 0) check("drop_lane", glog[0], 1);

        // Randomised traffic, backpressure and occasional reset.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_lanes();
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
